// File: rtl/osd_text_writer.sv
// Byte-stream writer for the 32x16 OSD text RAM: decodes CR/LF/BS/FF, tracks cursor and scroll.
// Optional macro OSD_TEXT_WRITER_WRAP_EN: printable at col 31 wraps to the next line.
module osd_text_writer #(
  parameter logic [19:0] TEXT_BASE = 20'h01000,
  parameter logic [7:0]  FILL_CHAR = 8'h20
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [7:0]  in_data,
  input  logic        in_valid,
  output logic        in_ready,
  output logic        wr_ena,
  output logic [19:0] wr_addr,
  output logic [7:0]  wr_data,
  output logic [4:0]  cursor_col,
  output logic [3:0]  cursor_row,
  output logic [3:0]  scroll_row,
  output logic        busy
);

  localparam int unsigned CNT_W = 9;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    CLEAR_ROW = 2'd1,
    CLEAR_ALL = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [3:0]         clr_row_q, clr_row_d;
  logic [4:0]         col_q, col_d;
  logic [3:0]         row_q, row_d;
  logic [3:0]         scroll_q, scroll_d;
  logic               wr_ena_q, wr_ena_d;
  logic [19:0]        wr_addr_q, wr_addr_d;
  logic [7:0]         wr_data_q, wr_data_d;
  logic               in_ready_q, in_ready_d;
  logic               busy_q, busy_d;

  logic [3:0]         phys_row;
  logic               take;
  logic               do_lf;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= CLEAR_ALL;
      cnt_q      <= '0;
      clr_row_q  <= '0;
      col_q      <= '0;
      row_q      <= '0;
      scroll_q   <= '0;
      wr_ena_q   <= 1'b0;
      wr_addr_q  <= '0;
      wr_data_q  <= '0;
      in_ready_q <= 1'b0;
      busy_q     <= 1'b1;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      clr_row_q  <= clr_row_d;
      col_q      <= col_d;
      row_q      <= row_d;
      scroll_q   <= scroll_d;
      wr_ena_q   <= wr_ena_d;
      wr_addr_q  <= wr_addr_d;
      wr_data_q  <= wr_data_d;
      in_ready_q <= in_ready_d;
      busy_q     <= busy_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    clr_row_d = clr_row_q;
    col_d     = col_q;
    row_d     = row_q;
    scroll_d  = scroll_q;
    wr_ena_d  = 1'b0;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    do_lf     = 1'b0;
    // 4-bit add gives the mod-16 physical row for free
    phys_row  = row_q + scroll_q;
    take      = in_valid && in_ready_q;

    case (state_q)
      IDLE: begin
        if (take) begin
          if (in_data >= 8'h20) begin
            wr_ena_d  = 1'b1;
            wr_addr_d = TEXT_BASE + 20'({phys_row, col_q});
            wr_data_d = in_data;
`ifdef OSD_TEXT_WRITER_WRAP_EN
            if (col_q == 5'd31) begin
              col_d = 5'd0;
              do_lf = 1'b1;
            end else begin
              col_d = col_q + 5'd1;
            end
`else
            if (col_q != 5'd31) col_d = col_q + 5'd1;
`endif
          end else begin
            case (in_data)
              8'h0D: col_d = 5'd0;
              8'h0A: do_lf = 1'b1;
              8'h08: if (col_q != 5'd0) col_d = col_q - 5'd1;
              8'h0C: begin
                col_d    = 5'd0;
                row_d    = 4'd0;
                scroll_d = 4'd0;
                cnt_d    = '0;
                state_d  = CLEAR_ALL;
              end
              default: ;
            endcase
          end
          // Bottom-row LF scrolls; the old top physical row becomes the new bottom
          if (do_lf) begin
            if (row_q != 4'd15) begin
              row_d = row_q + 4'd1;
            end else begin
              scroll_d  = scroll_q + 4'd1;
              clr_row_d = scroll_q;
              cnt_d     = '0;
              state_d   = CLEAR_ROW;
            end
          end
        end
      end
      CLEAR_ROW: begin
        wr_ena_d  = 1'b1;
        wr_addr_d = TEXT_BASE + 20'({clr_row_q, cnt_q[4:0]});
        wr_data_d = FILL_CHAR;
        cnt_d     = cnt_q + 9'd1;
        if (cnt_q[4:0] == 5'd31) state_d = IDLE;
      end
      CLEAR_ALL: begin
        wr_ena_d  = 1'b1;
        wr_addr_d = TEXT_BASE + 20'(cnt_q);
        wr_data_d = FILL_CHAR;
        cnt_d     = cnt_q + 9'd1;
        if (cnt_q == 9'd511) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    in_ready_d = (state_d == IDLE);
    busy_d     = (state_d != IDLE);
  end

  assign in_ready   = in_ready_q;
  assign busy       = busy_q;
  assign wr_ena     = wr_ena_q;
  assign wr_addr    = wr_addr_q;
  assign wr_data    = wr_data_q;
  assign cursor_col = col_q;
  assign cursor_row = row_q;
  assign scroll_row = scroll_q;

endmodule

// File: tb/tb_osd_text_writer.sv
// Self-checking bench for osd_text_writer: directed steps plus random bytes against a screen-level model.
module tb_osd_text_writer;

  logic        clk = 1'b0;
  logic        reset;
  logic [7:0]  in_data;
  logic        in_valid;
  logic        in_ready;
  logic        wr_ena;
  logic [19:0] wr_addr;
  logic [7:0]  wr_data;
  logic [4:0]  cursor_col;
  logic [3:0]  cursor_row;
  logic [3:0]  scroll_row;
  logic        busy;

  osd_text_writer dut (
    .clk(clk), .reset(reset), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready), .wr_ena(wr_ena), .wr_addr(wr_addr), .wr_data(wr_data),
    .cursor_col(cursor_col), .cursor_row(cursor_row), .scroll_row(scroll_row),
    .busy(busy)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [27:0] obs_q[$];
  int          obs_t[$];
  logic [27:0] exp_q[$];

  // Write monitor, sampled just after the active edge
  always @(posedge clk) begin
    #1;
    if (!reset && wr_ena) begin
      obs_q.push_back({wr_addr, wr_data});
      obs_t.push_back(cyc);
    end
  end

  // Reference model: cursor, scroll and the list of RAM writes the screen rules imply
  int m_col, m_row, m_scroll;
  int acc_cyc;

  function automatic void m_push(int addr, int data);
    exp_q.push_back({20'(addr), 8'(data)});
  endfunction

  function automatic void m_clear_all();
    for (int i = 0; i < 512; i++) m_push(32'h01000 + i, 32'h20);
  endfunction

  function automatic void m_reset();
    m_col = 0; m_row = 0; m_scroll = 0;
    m_clear_all();
  endfunction

  function automatic void m_lf();
    int old;
    if (m_row < 15) m_row++;
    else begin
      old = m_scroll;
      m_scroll = (m_scroll + 1) % 16;
      for (int c = 0; c < 32; c++) m_push(32'h01000 + old * 32 + c, 32'h20);
    end
  endfunction

  function automatic void m_byte(logic [7:0] b);
    if (b >= 8'h20) begin
      m_push(32'h01000 + ((m_row + m_scroll) % 16) * 32 + m_col, int'(b));
      if (m_col < 31) m_col++;
      else begin
`ifdef OSD_TEXT_WRITER_WRAP_EN
        m_col = 0;
        m_lf();
`endif
      end
    end else if (b == 8'h0D) m_col = 0;
    else if (b == 8'h0A) m_lf();
    else if (b == 8'h08) begin
      if (m_col > 0) m_col--;
    end else if (b == 8'h0C) begin
      m_col = 0; m_row = 0; m_scroll = 0;
      m_clear_all();
    end
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic send(input logic [7:0] b);
    int n;
    n = 0;
    @(negedge clk);
    while (!in_ready && n < 2000) begin @(negedge clk); n++; end
    if (!in_ready) chk("send_ready", 32'(in_ready), 32'd1);
    in_data  = b;
    in_valid = 1'b1;
    @(posedge clk);
    if (in_ready) m_byte(b);
    #1;
    acc_cyc  = cyc;
    in_valid = 1'b0;
    in_data  = 8'($urandom);
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    @(negedge clk);
    while (!in_ready && n < 2000) begin @(negedge clk); n++; end
    if (!in_ready) chk("wait_idle", 32'(in_ready), 32'd1);
  endtask

  task automatic check_cursor(input string tag);
    chk({tag, "_col"},    32'(cursor_col), 32'(m_col));
    chk({tag, "_row"},    32'(cursor_row), 32'(m_row));
    chk({tag, "_scroll"}, 32'(scroll_row), 32'(m_scroll));
  endtask

  task automatic check_writes(input string tag);
    int n;
    wait_idle();
    chk({tag, "_nwr"}, 32'(obs_q.size()), 32'(exp_q.size()));
    n = (obs_q.size() < exp_q.size()) ? obs_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) begin
      if (obs_q[i] !== exp_q[i]) begin
        chk({tag, "_wr"}, 32'(obs_q[i]), 32'(exp_q[i]));
        break;
      end
      if (i == 0 || i == n - 1) chk({tag, "_wr"}, 32'(obs_q[i]), 32'(exp_q[i]));
    end
    check_cursor(tag);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
    obs_q.delete(); obs_t.delete(); exp_q.delete();
  endtask

  initial begin
    int n;
    int t_a;
    logic [7:0] b;
    reset = 1'b1; in_valid = 1'b0; in_data = 8'h00;
    repeat (3) @(negedge clk);
    chk("rst_ready",  32'(in_ready), 32'd0);
    chk("rst_busy",   32'(busy), 32'd1);
    chk("rst_wr_ena", 32'(wr_ena), 32'd0);
    chk("rst_addr",   32'(wr_addr), 32'd0);
    chk("rst_cursor", 32'({cursor_row, cursor_col, scroll_row}), 32'd0);

    m_reset();
    reset = 1'b0;
    // Host holds a byte while the power-on clear runs; it must not be taken early
    in_data = 8'h41; in_valid = 1'b1;
    repeat (20) @(negedge clk);
    chk("clr_busy", 32'(busy), 32'd1);
    in_valid = 1'b0;
    check_writes("init_clear");
    chk("init_ready", 32'(in_ready), 32'd1);

    // Back-to-back printables with one-cycle write latency
    send(8'h41);
    t_a = acc_cyc;
    chk("bb_ready", 32'(in_ready), 32'd1);
    send(8'h42);
    chk("bb_lat", 32'(obs_t.size() > 0 ? obs_t[0] : -1), 32'(t_a));
    chk("bb_gap", 32'(obs_t.size() > 1 ? obs_t[1] - obs_t[0] : -1), 32'd1);
    check_writes("ab");

    send(8'h0D); send(8'h0A); send(8'hC1);
    check_writes("cr_lf_c1");
    chk("c1_pos", 32'({cursor_row, cursor_col}), 32'({4'd1, 5'd1}));

    // Walk to the bottom row, then scroll
    for (int i = 0; i < 14; i++) send(8'h0A);
    check_writes("to_row15");
    send(8'h0A);
    n = 0;
    while (!in_ready && n < 100) begin @(posedge clk); #1; n++; end
    chk("scroll_hold", 32'(n), 32'd32);
    check_writes("scroll_lf");
    send(8'h5A);
    check_writes("z_after_scroll");

    // Right-margin behaviour
    send(8'h0D);
    for (int i = 0; i < 31; i++) send(8'h2E);
    send(8'h58); send(8'h59);
    check_writes("margin");
`ifdef OSD_TEXT_WRITER_WRAP_EN
    chk("margin_col", 32'(cursor_col), 32'd1);
`else
    chk("margin_col", 32'(cursor_col), 32'd31);
`endif

    send(8'h0D); send(8'h08);
    check_writes("bs_col0");

    // Form feed with a non-zero scroll
    while (m_scroll != 5) send(8'h0A);
    send(8'h0D);
    for (int i = 0; i < 7; i++) send(8'h61 + 8'(i));
    check_writes("pre_ff");
    send(8'h0C);
    chk("ff_scroll", 32'(scroll_row), 32'd0);
    chk("ff_busy",   32'(busy), 32'd1);
    check_writes("ff");

    // Reset in the middle of a full clear restarts it from offset 0
    send(8'h0C);
    n = 0;
    while (obs_q.size() < 100 && n < 2000) begin @(negedge clk); n++; end
    chk("mid_cnt", 32'(obs_q.size()), 32'd100);
    reset = 1'b1;
    #1;
    chk("mid_rst_wr_ena", 32'(wr_ena), 32'd0);
    chk("mid_rst_ready",  32'(in_ready), 32'd0);
    chk("mid_rst_busy",   32'(busy), 32'd1);
    obs_q.delete(); obs_t.delete(); exp_q.delete();
    m_reset();
    @(negedge clk);
    reset = 1'b0;
    check_writes("mid_restart");

    // Random byte stream, control codes weighted up
    for (int i = 0; i < 400; i++) begin
      n = $urandom_range(0, 99);
      if (n < 2)       b = 8'h0C;
      else if (n < 12) b = 8'h0A;
      else if (n < 18) b = 8'h0D;
      else if (n < 24) b = 8'h08;
      else if (n < 28) b = 8'($urandom_range(0, 31));
      else             b = 8'($urandom_range(32, 255));
      send(b);
      if (i % 8 == 7) check_writes("rand");
    end
    check_writes("rand_end");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
